// File: rtl/lock_controller.sv
// lock_controller: keypad PIN lock FSM; `LOCK_PW_CHANGE_EN adds the NEWPW password-change state
module lock_controller #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PW     = 16'h1234,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  OPEN_CYCLES    = 1000,
    parameter int                  LOCKOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       unlocked,
    output logic       err_pulse,
    output logic       alarm,
    output logic [2:0] digit_count,
    output logic [2:0] fail_count
);
    localparam int TW = $clog2(OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES) + 1;
`ifdef LOCK_PW_CHANGE_EN
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT, NEWPW} state_t;
`else
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT} state_t;
`endif
    state_t state_q, state_d;
    logic [4*DIGITS-1:0] entry_q, entry_d, pw_q, pw_d, shifted;
    logic [TW-1:0] timer_q, timer_d, timer_dec;
    logic [2:0] cnt_d, fail_d;
    logic kv_q, kev, is_digit, is_hash, is_star, room, err_d;
    assign kev       = key_valid & ~kv_q;
    assign is_digit  = key_code < 4'd10;
    assign is_hash   = key_code == 4'd10;
    assign is_star   = key_code == 4'd11;
    assign room      = digit_count < 3'(DIGITS);
    assign shifted   = {entry_q[4*DIGITS-5:0], key_code};
    assign timer_dec = timer_q == '0 ? '0 : timer_q - 1'b1;
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = digit_count;
        fail_d  = fail_count;
        pw_d    = pw_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (kev && is_digit) begin
                entry_d = shifted;
                cnt_d   = 3'd1;
                state_d = ENTRY;
            end
            ENTRY: if (kev) begin
                if (is_digit && room) begin
                    entry_d = shifted;
                    cnt_d   = digit_count + 3'd1;
                end else if (is_star) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (is_hash) state_d = CHECK;
            end
            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (digit_count == 3'(DIGITS) && entry_q == pw_q) begin
                    fail_d  = '0;
                    timer_d = TW'(OPEN_CYCLES - 1);
                    state_d = OPEN;
                end else if (({1'b0, fail_count} + 4'd1) < 4'(MAX_FAIL)) begin
                    fail_d  = fail_count + 3'd1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = TW'(LOCKOUT_CYCLES - 1);
                    state_d = LOCKOUT;
                end
            end
            OPEN: begin
                timer_d = timer_dec;
                if (timer_q == '0 || (kev && is_star)) state_d = IDLE;
`ifdef LOCK_PW_CHANGE_EN
                else if (kev && is_hash) state_d = NEWPW;
`endif
            end
`ifdef LOCK_PW_CHANGE_EN
            NEWPW: begin
                timer_d = timer_dec;
                if (timer_q == '0 || (kev && (is_hash || is_star))) begin
                    if (kev && is_hash && timer_q != '0 && digit_count == 3'(DIGITS)) pw_d = entry_q;
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (kev && is_digit && room) begin
                    entry_d = shifted;
                    cnt_d   = digit_count + 3'd1;
                end
            end
`endif
            LOCKOUT: begin
                timer_d = timer_dec;
                if (timer_q == '0) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            pw_q        <= DEFAULT_PW;
            timer_q     <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            kv_q        <= 1'b0;
            unlocked    <= 1'b0;
            err_pulse   <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            pw_q        <= pw_d;
            timer_q     <= timer_d;
            digit_count <= cnt_d;
            fail_count  <= fail_d;
            kv_q        <= key_valid;
`ifdef LOCK_PW_CHANGE_EN
            unlocked    <= state_d == OPEN || state_d == NEWPW;
`else
            unlocked    <= state_d == OPEN;
`endif
            err_pulse   <= err_d;
            alarm       <= state_d == LOCKOUT;
        end
    end
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: vector table plus directed sequences for open time, lockout and reset
module tb_lock_controller;
    localparam int OPEN_C = 60;
    localparam int LOCK_C = 40;
    logic clock = 1'b0, reset = 1'b1, key_valid = 1'b0, unlocked, err_pulse, alarm;
    logic [3:0] key_code = '0;
    logic [2:0] digit_count, fail_count;
    int checks = 0, errors = 0, err_cnt = 0, unl_cnt = 0, alm_cnt = 0, base_e, base_u, base_a;
    typedef struct {logic [3:0] key; int dc; int fc; int ul; int errs;} vec_t;
    vec_t tbl [28];
    lock_controller #(.DIGITS(4), .DEFAULT_PW(16'h1234), .MAX_FAIL(3),
                      .OPEN_CYCLES(OPEN_C), .LOCKOUT_CYCLES(LOCK_C)) dut (
        .clock(clock), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .unlocked(unlocked), .err_pulse(err_pulse), .alarm(alarm),
        .digit_count(digit_count), .fail_count(fail_count));
    always #5 clock = ~clock;
    always @(negedge clock) begin
        if (err_pulse) err_cnt++;
        if (unlocked) unl_cnt++;
        if (alarm) alm_cnt++;
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic press(input logic [3:0] k);
        @(posedge clock); #1;
        key_code = k;
        key_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 key_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask
    task automatic press_seq(input logic [3:0] a, b, c, d, e);
        press(a); press(b); press(c); press(d); press(e);
    endtask
    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
    endtask
    task automatic wait_low(input string name, input bit alarm_sel);
        for (int i = 0; i < 300 && (alarm_sel ? alarm : unlocked); i++) @(negedge clock);
        chk(name, alarm_sel ? int'(alarm) : int'(unlocked), 0);
    endtask
    initial begin
        tbl = '{
            '{4'd1, 1, 0, 0, 0}, '{4'd2, 2, 0, 0, 0}, '{4'd3, 3, 0, 0, 0}, '{4'd5, 4, 0, 0, 0},
            '{4'd10, 0, 1, 0, 1}, '{4'd1, 1, 1, 0, 1}, '{4'd2, 2, 1, 0, 1}, '{4'd3, 3, 1, 0, 1},
            '{4'd4, 4, 1, 0, 1}, '{4'd10, 0, 0, 1, 1}, '{4'd11, 0, 0, 0, 1}, '{4'd1, 1, 0, 0, 1},
            '{4'd2, 2, 0, 0, 1}, '{4'd11, 0, 0, 0, 1}, '{4'd1, 1, 0, 0, 1}, '{4'd2, 2, 0, 0, 1},
            '{4'd3, 3, 0, 0, 1}, '{4'd4, 4, 0, 0, 1}, '{4'd5, 4, 0, 0, 1}, '{4'd10, 0, 0, 1, 1},
            '{4'd11, 0, 0, 0, 1}, '{4'd10, 0, 0, 0, 1}, '{4'd12, 0, 0, 0, 1}, '{4'd1, 1, 0, 0, 1},
            '{4'd2, 2, 0, 0, 1}, '{4'd3, 3, 0, 0, 1}, '{4'd15, 3, 0, 0, 1}, '{4'd10, 0, 1, 0, 2}};
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_unlocked", unlocked, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_dc", digit_count, 0);
        chk("rst_fc", fail_count, 0);
        base_e = err_cnt;
        foreach (tbl[i]) begin
            press(tbl[i].key);
            chk($sformatf("v%0d_dc", i), digit_count, tbl[i].dc);
            chk($sformatf("v%0d_fc", i), fail_count, tbl[i].fc);
            chk($sformatf("v%0d_ul", i), unlocked, tbl[i].ul);
            chk($sformatf("v%0d_err", i), err_cnt - base_e, tbl[i].errs);
        end
        press(1); press(2);
        chk("mid_dc", digit_count, 2);
        chk("mid_fc", fail_count, 1);
        do_reset();
        chk("mid_rst_dc", digit_count, 0);
        chk("mid_rst_fc", fail_count, 0);
        chk("mid_rst_ul", unlocked, 0);
        press(1); press(2); press(3); press(4);
        base_u = unl_cnt;
        press(10);
        chk("open_ul", unlocked, 1);
        wait_low("open_end", 1'b0);
        chk("open_len", unl_cnt - base_u, OPEN_C);
        chk("open_fc", fail_count, 0);
        base_e = err_cnt;
        press_seq(9, 9, 9, 9, 10);
        chk("lk1_fc", fail_count, 1);
        press_seq(9, 9, 9, 9, 10);
        chk("lk2_fc", fail_count, 2);
        base_a = alm_cnt;
        press_seq(9, 9, 9, 9, 10);
        chk("lk_alarm", alarm, 1);
        press_seq(1, 2, 3, 4, 10);
        chk("lk_ign_dc", digit_count, 0);
        chk("lk_ign_ul", unlocked, 0);
        wait_low("lk_end", 1'b1);
        chk("lk_len", alm_cnt - base_a, LOCK_C);
        chk("lk_fc", fail_count, 0);
        chk("lk_errs", err_cnt - base_e, 2);
`ifdef LOCK_PW_CHANGE_EN
        press_seq(1, 2, 3, 4, 10);
        chk("pw_open", unlocked, 1);
        press(10); press(5); press(6); press(7); press(8);
        chk("pw_dc", digit_count, 4);
        chk("pw_ul", unlocked, 1);
        press(10);
        chk("pw_set_ul", unlocked, 0);
        chk("pw_set_dc", digit_count, 0);
        base_e = err_cnt;
        press_seq(1, 2, 3, 4, 10);
        chk("pw_old_ul", unlocked, 0);
        chk("pw_old_err", err_cnt - base_e, 1);
        press_seq(5, 6, 7, 8, 10);
        chk("pw_new_ul", unlocked, 1);
        chk("pw_new_fc", fail_count, 0);
        do_reset();
        press_seq(1, 2, 3, 4, 10);
        chk("pw_rst_ul", unlocked, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
